// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and FSM state type for the ALU arbiter
package alu_pkg;
    localparam int ALU_OPC_W  = 3;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way priority-pointer arbiter producing a one-hot grant
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);
    // favour the requester the pointer names, fall back to the other one
    always_comb
        grant = valid[prio] ? (prio ? 2'b10 : 2'b01) : valid[~prio] ? (prio ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one registered ALU between two requesters
module alu_arbiter import alu_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*DATA_W-1:0]    req_op1,
    input  logic [2*DATA_W-1:0]    req_op2,
    input  logic [2*ALU_OPC_W-1:0] req_opcode,
    input  logic [2*TAG_W-1:0]     req_tag,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W:0]        rsp_result,
    output logic                   rsp_overflow,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [DATA_W-1:0]      alu_operand1,
    output logic [DATA_W-1:0]      alu_operand2,
    output logic [ALU_OPC_W-1:0]   alu_opcode,
    output logic                   alu_en,
    input  logic [DATA_W:0]        alu_result,
    input  logic                   alu_overflow
);
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    state_t           state;
    logic             prio;
    logic             gnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;

    rr_arb2 u_arb (.valid(req_valid), .prio(prio), .grant(grant));

    // only an idle, out-of-reset arbiter offers its grant
    always_comb req_ready = (state == IDLE && rst) ? grant : 2'b00;

    // sequencer: accept, pulse the ALU, wait out its latency, hold the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            gnt          <= 1'b0;
            cnt          <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_opcode   <= '0;
            alu_en       <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_tag      <= '0;
        end else begin
            case (state)
                IDLE: if (req_ready != 2'b00) begin
                    alu_operand1 <= req_ready[1] ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
                    alu_operand2 <= req_ready[1] ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
                    alu_opcode   <= req_ready[1] ? req_opcode[2*ALU_OPC_W-1:ALU_OPC_W] : req_opcode[ALU_OPC_W-1:0];
                    rsp_tag      <= req_ready[1] ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
                    gnt          <= req_ready[1];
                    alu_en       <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    alu_en <= 1'b0;
                    cnt    <= CNT_W'(ALU_LAT);
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_result   <= alu_result;
                        rsp_overflow <= alu_overflow;
                        rsp_valid    <= gnt ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end
                end
                RESP: if (rsp_ready[gnt]) begin
                    rsp_valid <= 2'b00;
                    prio      <= ~gnt;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench run against ALU_LAT=1 and ALU_LAT=3 builds
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [1:0]    req_ready;
        logic [1:0]    rsp_valid;
        logic [DW:0]   rsp_result;
        logic          rsp_overflow;
        logic [TW-1:0] rsp_tag;
        logic [DW-1:0] alu_operand1;
        logic [DW-1:0] alu_operand2;
        logic [2:0]    alu_opcode;
        logic          alu_en;
    } obs_t;

    typedef struct packed {
        logic [1:0]    who;
        logic [TW-1:0] tag;
        logic [DW+1:0] res;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    int              sel = 0;
    int              lat = 1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      rsp_ready = '0;
    logic [2*DW-1:0] req_op1 = '0;
    logic [2*DW-1:0] req_op2 = '0;
    logic [5:0]      req_opcode = '0;
    logic [2*TW-1:0] req_tag = '0;
    obs_t            o0, o1, o;
    logic [DW+1:0]   pipe0 [3];
    logic [DW+1:0]   pipe1 [3];
    logic [2:0]      pv0 = '0;
    logic [2:0]      pv1 = '0;
    int              errors = 0;
    int              checks = 0;

    always #5 clk = ~clk;

    assign o = (sel == 0) ? o0 : o1;

    // spec ALU: zero-extended sum for every opcode, signed-overflow flag in the top bit
    function automatic logic [DW+1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]), s};
    endfunction

    // registered ALU models; output is junk whenever no issued result is due
    always @(posedge clk) begin
        pv0      <= {pv0[1:0], o0.alu_en};
        pv1      <= {pv1[1:0], o1.alu_en};
        pipe0[0] <= alu_ref(o0.alu_operand1, o0.alu_operand2);
        pipe1[0] <= alu_ref(o1.alu_operand1, o1.alu_operand2);
        for (int i = 1; i < 3; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end

    alu_arbiter #(.DATA_W(DW), .TAG_W(TW), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(sel == 0 ? req_valid : 2'b00), .req_ready(o0.req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode), .req_tag(req_tag),
        .rsp_valid(o0.rsp_valid), .rsp_ready(sel == 0 ? rsp_ready : 2'b00),
        .rsp_result(o0.rsp_result), .rsp_overflow(o0.rsp_overflow), .rsp_tag(o0.rsp_tag),
        .alu_operand1(o0.alu_operand1), .alu_operand2(o0.alu_operand2),
        .alu_opcode(o0.alu_opcode), .alu_en(o0.alu_en),
        .alu_result(pv0[0] ? pipe0[0][DW:0] : 33'h0_5A5A_5A5A),
        .alu_overflow(pv0[0] ? pipe0[0][DW+1] : 1'b1)
    );

    alu_arbiter #(.DATA_W(DW), .TAG_W(TW), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(sel == 1 ? req_valid : 2'b00), .req_ready(o1.req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode), .req_tag(req_tag),
        .rsp_valid(o1.rsp_valid), .rsp_ready(sel == 1 ? rsp_ready : 2'b00),
        .rsp_result(o1.rsp_result), .rsp_overflow(o1.rsp_overflow), .rsp_tag(o1.rsp_tag),
        .alu_operand1(o1.alu_operand1), .alu_operand2(o1.alu_operand2),
        .alu_opcode(o1.alu_opcode), .alu_en(o1.alu_en),
        .alu_result(pv1[2] ? pipe1[2][DW:0] : 33'h0_5A5A_5A5A),
        .alu_overflow(pv1[2] ? pipe1[2][DW+1] : 1'b1)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] opc, input logic [TW-1:0] t);
        req_op1[r*DW +: DW]  = a;
        req_op2[r*DW +: DW]  = b;
        req_opcode[r*3 +: 3] = opc;
        req_tag[r*TW +: TW]  = t;
    endtask

    task automatic rnd(input int r);
        drive(r, $urandom, $urandom, 3'($urandom_range(7, 0)), TW'($urandom_range(15, 0)));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rsp_ready = 2'b00;
        rnd(0);
        rnd(1);
        req_valid = 2'b11;
        tick();
        checks++;
        if (o.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready lat=%0d: got %b want 00", lat, o.req_ready);
        end
        checks++;
        if ({o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag, o.alu_operand1, o.alu_operand2, o.alu_opcode, o.alu_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs lat=%0d: got rv=%b res=%h ov=%b tag=%h a1=%h a2=%h opc=%h en=%b want all zero",
                     lat, o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag, o.alu_operand1, o.alu_operand2, o.alu_opcode, o.alu_en);
        end
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (o.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_prio lat=%0d: got %b want 01", lat, o.req_ready);
        end
        req_valid = 2'b00;
        #1;
        checks++;
        if (o.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_drop lat=%0d: got %b want 00", lat, o.req_ready);
        end
    endtask

    task automatic test_basic();
        int en_cnt = 0;
        int rsp_at = 0;
        do_reset();
        drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 4'd3);
        req_valid = 2'b01;
        #1;
        checks++;
        if (o.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL basic_grant lat=%0d: got %b want 01", lat, o.req_ready);
        end
        for (int n = 1; n <= 12 && rsp_at == 0; n++) begin
            tick();
            if (n == 1) req_valid = 2'b00;
            if (o.alu_en === 1'b1) en_cnt++;
            if (o.rsp_valid !== 2'b00) rsp_at = n;
        end
        checks++;
        if (en_cnt != 1) begin
            errors++;
            $display("FAIL basic_alu_en_cycles lat=%0d: got %0d want 1", lat, en_cnt);
        end
        checks++;
        if (rsp_at != lat + 2) begin
            errors++;
            $display("FAIL basic_rsp_latency lat=%0d: got cycle %0d want %0d", lat, rsp_at, lat + 2);
        end
        checks++;
        if ({o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag} !== {2'b01, 33'h1_FFFF_FFFE, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL basic_rsp lat=%0d: got rv=%b res=%h ov=%b tag=%0d want rv=01 res=1fffffffe ov=0 tag=3",
                     lat, o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag);
        end
        rsp_ready = 2'b01;
        tick();
        checks++;
        if (o.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL basic_rsp_drop lat=%0d: got %b want 00", lat, o.rsp_valid);
        end
    endtask

    task automatic test_alternate();
        exp_t q[$];
        exp_t e;
        int mprio = 0;
        int last_acc = -1;
        int done = 0;
        logic [1:0] acc;
        do_reset();
        rnd(0);
        rnd(1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int n = 0; n < 80 && done < 6; n++) begin
            if (o.req_ready !== 2'b00) begin
                checks++;
                if (o.req_ready !== (mprio != 0 ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL alt_grant lat=%0d: got %b want requester %0d", lat, o.req_ready, mprio);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (n - last_acc != lat + 3) begin
                        errors++;
                        $display("FAIL alt_turnaround lat=%0d: got %0d cycles want %0d", lat, n - last_acc, lat + 3);
                    end
                end
                last_acc = n;
                e.who = (mprio != 0) ? 2'b10 : 2'b01;
                e.tag = req_tag[mprio*TW +: TW];
                e.res = alu_ref(req_op1[mprio*DW +: DW], req_op2[mprio*DW +: DW]);
                q.push_back(e);
            end
            if (o.rsp_valid !== 2'b00) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({o.rsp_valid, o.rsp_tag, o.rsp_overflow, o.rsp_result} !== {e.who, e.tag, e.res}) begin
                    errors++;
                    $display("FAIL alt_rsp lat=%0d: got rv=%b tag=%h ov=%b res=%h want rv=%b tag=%h ov=%b res=%h",
                             lat, o.rsp_valid, o.rsp_tag, o.rsp_overflow, o.rsp_result, e.who, e.tag, e.res[DW+1], e.res[DW:0]);
                end
                mprio = e.who[1] ? 0 : 1;
                done++;
            end
            acc = o.req_ready;
            tick();
            if (acc != 2'b00) rnd(acc[1] ? 1 : 0);
            #1;
        end
        checks++;
        if (done != 6) begin
            errors++;
            $display("FAIL alt_count lat=%0d: got %0d responses want 6", lat, done);
        end
    endtask

    task automatic test_hold();
        logic [DW+1:0] er;
        logic [TW-1:0] et;
        do_reset();
        rnd(0);
        er = alu_ref(req_op1[DW-1:0], req_op2[DW-1:0]);
        et = req_tag[TW-1:0];
        req_valid = 2'b01;
        tick();
        rnd(1);
        req_valid = 2'b10;
        for (int n = 0; n < 20 && o.rsp_valid === 2'b00; n++) tick();
        checks++;
        if (o.rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL hold_rsp_valid lat=%0d: got %b want 01", lat, o.rsp_valid);
        end
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({o.rsp_valid, o.req_ready, o.rsp_tag, o.rsp_overflow, o.rsp_result} !== {2'b01, 2'b00, et, er}) begin
                errors++;
                $display("FAIL hold_stable lat=%0d cycle %0d: got rv=%b rr=%b tag=%h ov=%b res=%h want rv=01 rr=00 tag=%h ov=%b res=%h",
                         lat, i, o.rsp_valid, o.req_ready, o.rsp_tag, o.rsp_overflow, o.rsp_result, et, er[DW+1], er[DW:0]);
            end
        end
        rsp_ready = 2'b01;
        tick();
        checks++;
        if ({o.rsp_valid, o.req_ready} !== {2'b00, 2'b10}) begin
            errors++;
            $display("FAIL hold_next_grant lat=%0d: got rv=%b rr=%b want rv=00 rr=10", lat, o.rsp_valid, o.req_ready);
        end
    endtask

    task automatic test_overflow();
        logic [TW-1:0] t;
        t = TW'($urandom_range(15, 0));
        do_reset();
        drive(1, 32'h7FFF_FFFF, 32'h0000_0001, 3'b101, t);
        req_valid = 2'b10;
        #1;
        checks++;
        if (o.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL ovf_grant lat=%0d: got %b want 10", lat, o.req_ready);
        end
        tick();
        req_valid = 2'b00;
        drive(1, $urandom, $urandom, 3'b010, ~t);
        #1;
        for (int n = 0; n < 20 && o.rsp_valid === 2'b00; n++) begin
            checks++;
            if ({o.alu_operand1, o.alu_operand2, o.alu_opcode} !== {32'h7FFF_FFFF, 32'h0000_0001, 3'b101}) begin
                errors++;
                $display("FAIL ovf_operands lat=%0d: got a1=%h a2=%h opc=%b want 7fffffff 00000001 101",
                         lat, o.alu_operand1, o.alu_operand2, o.alu_opcode);
            end
            tick();
        end
        checks++;
        if ({o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag} !== {2'b10, 33'h0_8000_0000, 1'b1, t}) begin
            errors++;
            $display("FAIL ovf_rsp lat=%0d: got rv=%b res=%h ov=%b tag=%h want rv=10 res=080000000 ov=1 tag=%h",
                     lat, o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag, t);
        end
        rsp_ready = 2'b10;
        tick();
        checks++;
        if (o.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL ovf_rsp_drop lat=%0d: got %b want 00", lat, o.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] er;
        logic [TW-1:0] et;
        int seen = 0;
        do_reset();
        rnd(0);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 20 && o.rsp_valid === 2'b00; n++) tick();
        tick();
        rnd(1);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if ({o.req_ready, o.rsp_valid, o.rsp_result, o.rsp_overflow, o.rsp_tag, o.alu_operand1, o.alu_operand2, o.alu_opcode, o.alu_en} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs lat=%0d: got rv=%b res=%h tag=%h a1=%h a2=%h opc=%h en=%b want all zero",
                     lat, o.rsp_valid, o.rsp_result, o.rsp_tag, o.alu_operand1, o.alu_operand2, o.alu_opcode, o.alu_en);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < lat + 4; i++) begin
            tick();
            if (o.rsp_valid !== 2'b00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_rsp lat=%0d: got %0d cycles with rsp_valid want 0", lat, seen);
        end
        rsp_ready = 2'b00;
        rnd(0);
        rnd(1);
        req_valid = 2'b11;
        #1;
        checks++;
        if (o.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset_prio lat=%0d: got %b want 01", lat, o.req_ready);
        end
        req_valid = 2'b10;
        er = alu_ref(req_op1[2*DW-1:DW], req_op2[2*DW-1:DW]);
        et = req_tag[2*TW-1:TW];
        #1;
        checks++;
        if (o.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_grant1 lat=%0d: got %b want 10", lat, o.req_ready);
        end
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 20 && o.rsp_valid === 2'b00; n++) tick();
        checks++;
        if ({o.rsp_valid, o.rsp_tag, o.rsp_overflow, o.rsp_result} !== {2'b10, et, er}) begin
            errors++;
            $display("FAIL mid_reset_rsp lat=%0d: got rv=%b tag=%h ov=%b res=%h want rv=10 tag=%h ov=%b res=%h",
                     lat, o.rsp_valid, o.rsp_tag, o.rsp_overflow, o.rsp_result, et, er[DW+1], er[DW:0]);
        end
        rsp_ready = 2'b10;
        tick();
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s;
            lat = (s == 0) ? 1 : 3;
            test_reset();
            test_basic();
            test_alternate();
            test_hold();
            test_overflow();
            test_reset_mid();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-way arbiter for the shared registered ALU. Two requesters each present an operation as operands, opcode and tag over a valid/ready handshake. The arbiter grants one request at a time in round-robin order, drives the ALU operand/opcode/enable inputs, and waits the fixed ALU latency. It then captures the 33-bit result and the overflow flag and returns them to the granted requester over a valid/ready response channel. It sits between the issue logic and the ALU instance.

## Interface
Parameters:
- DATA_W, 32, operand width; result width is DATA_W+1
- TAG_W, 4, requester-supplied tag returned with the response
- ALU_LAT, 1, cycles from the edge sampling alu_en=1 to alu_result valid (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_op1  in  2*DATA_W  operand 1, slice i for requester i
- req_op2  in  2*DATA_W  operand 2, sliced as above
- req_opcode  in  2*3  ALU opcode per requester
- req_tag  in  2*TAG_W  tag per requester
- rsp_valid  out  2  response valid, one-hot or zero
- rsp_ready  in  2  response consumed
- rsp_result  out  DATA_W+1  captured ALU result
- rsp_overflow  out  1  captured ALU overflow
- rsp_tag  out  TAG_W  tag of served request
- alu_operand1  out  DATA_W  to ALU operand1
- alu_operand2  out  DATA_W  to ALU operand2
- alu_opcode  out  3  to ALU opcode
- alu_en  out  1  ALU enable
- alu_result  in  DATA_W+1  from ALU
- alu_overflow  in  1  from ALU

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = requester at priority pointer `prio` if its valid is high, else the other requester if its valid is high.
  - req_ready[grant] = 1 combinationally. No other state asserts req_ready.
  - On the handshake edge: latch op1/op2/opcode/tag of the granted requester and record `gnt`, then go to ISSUE.
- ISSUE: alu_en=1 for exactly one cycle. Load the wait counter with ALU_LAT. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, latch alu_result/alu_overflow into the rsp registers on that edge and go to RESP.
- RESP:
  - rsp_valid[gnt]=1; rsp_result/overflow/tag are stable.
  - Hold until rsp_ready[gnt]. On that edge set prio = ~gnt and go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- alu_operand1/2 and alu_opcode are always driven from the latched registers, so they are stable through ISSUE and WAIT. The opcode is passed through uninterpreted.
- Requester rule: once req_valid is asserted, the requester holds it and its payload until req_ready. Dropping valid in IDLE before the grant is permitted and is simply not granted.
- Both valid with prio=0: requester 0 is served, then requester 1. Alternation is strict under continuous contention.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, prio=0, gnt=0, counter=0.
  - alu_operand1/2=0, alu_opcode=0, alu_en=0.
  - rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_tag=0.
  - req_ready=0 while rst is low.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and prio returns to 0.
- Request accepted at edge k:
  - alu_en is high during cycle k→k+1.
  - The result is captured at edge k+1+ALU_LAT.
  - rsp_valid rises after that edge.
- With rsp_ready held high: response handshake at edge k+2+ALU_LAT and IDLE from that edge. The next accept is at the earliest at edge k+3+ALU_LAT. Throughput is one op per ALU_LAT+3 cycles.
- No combinational path from alu_result to any output.

## Structure
- Shared package alu_pkg holds ALU_OPC_W=3, the state enum (IDLE/ISSUE/WAIT/RESP) and default DATA_W/TAG_W constants. Opcode encodings remain owned by the ALU.
- One sub-module, rr_arb2: inputs valid[1:0] and prio; outputs one-hot grant[1:0].

## Test plan
Bench ALU model: registered with latency ALU_LAT; result = {1'b0,op1}+{1'b0,op2} for all opcodes; overflow = signed overflow.
- Reset, then requester 0 issues op1=32'hFFFFFFFF, op2=32'hFFFFFFFF, opcode 3'b001, tag 3 → alu_en high for exactly 1 cycle; rsp_valid[0] with result 33'h1FFFFFFFE, overflow 0, tag 3, ALU_LAT+1 edges after accept.
- Both requesters valid continuously with rsp_ready=2'b11 → grants alternate 0,1,0,1; each response carries its own tag; turnaround is ALU_LAT+3 cycles.
- rsp_ready[0] held low 5 cycles in RESP → rsp_valid[0] and payload stable; req_ready stays 0 despite requester 1 being valid; requester 1 is granted on the cycle after the handshake.
- Operands 32'h7FFFFFFF + 32'h00000001 from requester 1 → result 33'h080000000, overflow 1; alu_operand1/2 are unchanged while the requester changes its payload after accept.
- rst pulsed low during WAIT → all outputs zero immediately; no rsp_valid afterwards; the next request is from requester 1 only but granted normally with prio=0.
- ALU_LAT=3 build: accept at edge k → capture at edge k+4, alu_en never reasserted during WAIT.
